// File: rtl/spi_ram_pkg.sv
// Shared state encoding, command codes and word geometry for the SPI-to-RAM bridge.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(BYTE_W);

  function automatic logic [1:0] cmd_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 2];
  endfunction

  // Write frames only carry 0x codes, read frames only 1x codes.
  function automatic logic cmd_fits(input state_e st, input logic [1:0] cmd);
    logic fits;
    case (st)
      WRITE:               fits = ~cmd[1];
      READ_ADD, READ_DATA: fits = cmd[1];
      default:             fits = 1'b0;
    endcase
    return fits;
  endfunction

endpackage

// File: rtl/spi_ram_wrapper_if.sv
// SPI pin bundle between an external master and the RAM bridge slave.
interface spi_ram_wrapper_if;

  logic MOSI;
  logic SS_n;
  logic MISO;

  modport master (
    output MOSI,
    output SS_n,
    input  MISO
  );

  modport slave (
    input  MOSI,
    input  SS_n,
    output MISO
  );

endinterface

// File: rtl/spi_ram_sp.sv
// Single-port RAM with a registered command decoder fed by 10-bit slave words.
// Build option SPI_WR_ADDR_AUTOINC_EN: post-increment wr_addr after every data write.
module spi_ram_sp
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] din_i,
  input  logic              rx_valid_i,
  output logic [BYTE_W-1:0] dout_o,
  output logic              tx_valid_o
);

  logic [BYTE_W-1:0]    mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic [BYTE_W-1:0]    dout_q;
  logic                 tx_valid_q;

  logic [1:0]           cmd;
  logic [BYTE_W-1:0]    payload;

  always_comb begin
    cmd     = cmd_of(din_i);
    payload = din_i[BYTE_W-1:0];
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (!rst && rx_valid_i && (cmd == CMD_WR_DATA)) begin
      mem[wr_addr_q] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      if (rx_valid_i) begin
        unique case (cmd)
          CMD_WR_ADDR: wr_addr_q <= payload[ADDR_SIZE-1:0];
          CMD_WR_DATA: begin
`ifdef SPI_WR_ADDR_AUTOINC_EN
            // Address width spans the full depth, so natural overflow wraps 255 -> 0.
            wr_addr_q <= wr_addr_q + 1'b1;
`else
            wr_addr_q <= wr_addr_q;
`endif
          end
          CMD_RD_ADDR: rd_addr_q <= payload[ADDR_SIZE-1:0];
          CMD_RD_DATA: begin
            dout_q     <= mem[rd_addr_q];
            tx_valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign dout_o     = dout_q;
  assign tx_valid_o = tx_valid_q;

endmodule

// File: rtl/spi_ram_wrapper.sv
// SPI slave front end: frames 10-bit command words from MOSI, drives the RAM decoder,
// and serializes read bytes MSB-first on MISO.
module spi_ram_wrapper
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_ram_wrapper_if.slave spi
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] din_q;
  logic              rx_valid_q;
  logic              rd_addr_received_q;
  logic              miso_q;
  logic [BYTE_W-1:0] tx_sr_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic              tx_busy_q;

  logic [WORD_W-1:0] word_next;
  logic [1:0]        cmd_next;
  logic              word_done;
  logic              word_ok;
  logic [BYTE_W-1:0] dout;
  logic              tx_valid;

  always_comb begin
    word_next = {din_q[WORD_W-2:0], spi.MOSI};
    cmd_next  = cmd_of(word_next);
    word_done = (cnt_q == CNT_LAST);
    word_ok   = cmd_fits(state_q, cmd_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      din_q              <= '0;
      rx_valid_q         <= 1'b0;
      rd_addr_received_q <= 1'b0;
      miso_q             <= 1'b0;
      tx_sr_q            <= '0;
      tx_cnt_q           <= '0;
      tx_busy_q          <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!spi.SS_n) state_q <= CHK_CMD;
        end
        CHK_CMD: begin
          if (spi.SS_n)                state_q <= IDLE;
          else if (!spi.MOSI)          state_q <= WRITE;
          else if (rd_addr_received_q) state_q <= READ_DATA;
          else                         state_q <= READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (spi.SS_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != CNT_FULL) begin
            // Once a full word is in, further MOSI bits are ignored until the frame closes.
            din_q <= word_next;
            cnt_q <= cnt_q + 1'b1;
            if (word_done && word_ok) begin
              rx_valid_q <= 1'b1;
              if (cmd_next == CMD_RD_ADDR)      rd_addr_received_q <= 1'b1;
              else if (cmd_next == CMD_RD_DATA) rd_addr_received_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (spi.SS_n) begin
        miso_q    <= 1'b0;
        tx_busy_q <= 1'b0;
      end else if (tx_valid && (state_q == READ_DATA)) begin
        miso_q    <= dout[BYTE_W-1];
        tx_sr_q   <= {dout[BYTE_W-2:0], 1'b0};
        tx_cnt_q  <= CNT_W'(1);
        tx_busy_q <= 1'b1;
      end else if (tx_busy_q) begin
        if (tx_cnt_q == TX_LAST) begin
          miso_q    <= 1'b0;
          tx_busy_q <= 1'b0;
        end else begin
          miso_q   <= tx_sr_q[BYTE_W-1];
          tx_sr_q  <= {tx_sr_q[BYTE_W-2:0], 1'b0};
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign spi.MISO = miso_q;

  spi_ram_sp #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) ram (
    .clk        (clk),
    .rst        (rst),
    .din_i      (din_q),
    .rx_valid_i (rx_valid_q),
    .dout_o     (dout),
    .tx_valid_o (tx_valid)
  );

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Directed plus randomized frames against a frame-level model of the SPI RAM bridge.
module tb_spi_ram_wrapper;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  spi_ram_wrapper_if spi_bus ();

  spi_ram_wrapper dut (
    .clk (clk),
    .rst (rst),
    .spi (spi_bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_m [256];
  logic [7:0] wr_addr_m;
  logic [7:0] rd_addr_m;
  logic       rd_flag_m;
  logic [7:0] wq [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Effect of one complete frame; rd_en says whether a byte should come back on MISO.
  task automatic model_apply(input logic sel, input logic [9:0] w,
                             output logic rd_en, output logic [7:0] rd_byte);
    logic [1:0] cmd;
    logic       was_rd_data;
    cmd         = w[9:8];
    was_rd_data = sel && rd_flag_m;
    rd_en       = 1'b0;
    rd_byte     = 8'h00;
    if (cmd[1] == sel) begin
      case (cmd)
        2'b00: wr_addr_m = w[7:0];
        2'b01: begin
          mem_m[wr_addr_m] = w[7:0];
          wq.push_back(wr_addr_m);
`ifdef SPI_WR_ADDR_AUTOINC_EN
          wr_addr_m = wr_addr_m + 8'd1;
`endif
        end
        2'b10: begin
          rd_addr_m = w[7:0];
          rd_flag_m = 1'b1;
        end
        default: begin
          rd_flag_m = 1'b0;
          rd_byte   = mem_m[rd_addr_m];
          rd_en     = was_rd_data;
        end
      endcase
    end
  endtask

  task automatic frame(input logic sel, input logic [9:0] w, input string tag);
    logic       rd_en;
    logic [7:0] rd_byte;
    logic       exp;
    model_apply(sel, w, rd_en, rd_byte);
    spi_bus.SS_n = 1'b0;
    tick();
    spi_bus.MOSI = sel;
    tick();
    for (int i = 9; i >= 0; i--) begin
      spi_bus.MOSI = w[i];
      tick();
    end
    spi_bus.MOSI = 1'($urandom);
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (rd_en && k >= 2 && k <= 9) ? rd_byte[9-k] : 1'b0;
      chk($sformatf("%s miso[%0d]", tag, k), 32'(spi_bus.MISO), 32'(exp));
    end
    spi_bus.SS_n = 1'b1;
    tick();
    tick();
    chk({tag, " idle"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  task automatic abort_frame(input logic [9:0] w, input int nbits, input string tag);
    spi_bus.SS_n = 1'b0;
    tick();
    spi_bus.MOSI = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      spi_bus.MOSI = w[9-i];
      tick();
    end
    spi_bus.SS_n = 1'b1;
    tick();
    chk({tag, " state"}, 32'(dut.state_q), 32'(IDLE));
    chk({tag, " cnt"}, 32'(dut.cnt_q), 32'd0);
    chk({tag, " miso"}, 32'(spi_bus.MISO), 32'd0);
    tick();
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    logic       s;

    rst          = 1'b1;
    spi_bus.SS_n = 1'b1;
    spi_bus.MOSI = 1'b0;
    repeat (3) tick();
    chk("rst miso", 32'(spi_bus.MISO), 32'd0);
    chk("rst state", 32'(dut.state_q), 32'(IDLE));
    chk("rst flag", 32'(dut.rd_addr_received_q), 32'd0);
    chk("rst wr_addr", 32'(dut.ram.wr_addr_q), 32'd0);
    chk("rst rd_addr", 32'(dut.ram.rd_addr_q), 32'd0);
    chk("rst dout", 32'(dut.ram.dout_q), 32'd0);
    chk("rst tx_valid", 32'(dut.ram.tx_valid_q), 32'd0);
    rst       = 1'b0;
    wr_addr_m = 8'h00;
    rd_addr_m = 8'h00;
    rd_flag_m = 1'b0;
    tick();

    frame(1'b0, {2'b00, 8'hFE}, "wr_addr");
    chk("wr_addr val", 32'(dut.ram.wr_addr_q), 32'h0FE);

    frame(1'b0, {2'b01, 8'hAA}, "wr_data");
    chk("mem254", 32'(dut.ram.mem[254]), 32'h0AA);

    frame(1'b1, {2'b10, 8'hFE}, "rd_addr");
    chk("rd_addr val", 32'(dut.ram.rd_addr_q), 32'h0FE);
    chk("flag set", 32'(dut.rd_addr_received_q), 32'd1);

    frame(1'b1, {2'b11, 8'hF0}, "rd_data");
    chk("dout", 32'(dut.ram.dout_q), 32'h0AA);
    chk("flag clr", 32'(dut.rd_addr_received_q), 32'd0);

    frame(1'b0, {2'b00, 8'hFE}, "rewind");
    abort_frame({2'b01, 8'h55}, 5, "abort");
    chk("abort mem", 32'(dut.ram.mem[254]), 32'h0AA);

    frame(1'b0, {2'b00, 8'hFF}, "wrap addr");
    frame(1'b0, {2'b01, 8'h11}, "wrap w1");
    frame(1'b0, {2'b01, 8'h22}, "wrap w2");
`ifdef SPI_WR_ADDR_AUTOINC_EN
    chk("inc mem255", 32'(dut.ram.mem[255]), 32'h011);
    chk("inc mem0", 32'(dut.ram.mem[0]), 32'h022);
    chk("inc wr_addr", 32'(dut.ram.wr_addr_q), 32'h001);
`else
    chk("hold mem255", 32'(dut.ram.mem[255]), 32'h022);
    chk("hold wr_addr", 32'(dut.ram.wr_addr_q), 32'h0FF);
`endif

    frame(1'b0, {2'b10, 8'h00}, "mis sel0");
    chk("mis sel0 flag", 32'(dut.rd_addr_received_q), 32'd0);
    chk("mis sel0 rd_addr", 32'(dut.ram.rd_addr_q), 32'h0FE);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(3))
        0: begin
          a = 8'($urandom);
          d = 8'($urandom);
          frame(1'b0, {2'b00, a}, "r wa");
          frame(1'b0, {2'b01, d}, "r wd");
          chk("r mem", 32'(dut.ram.mem[a]), 32'(mem_m[a]));
        end
        1: begin
          a = wq[$urandom_range(wq.size() - 1)];
          frame(1'b1, {2'b10, a}, "r ra");
          frame(1'b1, {2'b11, 8'($urandom)}, "r rd");
        end
        2: begin
          s = 1'($urandom);
          frame(s, {~s, 1'($urandom), 8'($urandom)}, "r mis");
          chk("r mis flag", 32'(dut.rd_addr_received_q), 32'(rd_flag_m));
          chk("r mis wr_addr", 32'(dut.ram.wr_addr_q), 32'(wr_addr_m));
          chk("r mis rd_addr", 32'(dut.ram.rd_addr_q), 32'(rd_addr_m));
        end
        default: begin
          a = wr_addr_m;
          abort_frame({2'b01, 8'($urandom)}, $urandom_range(1, 9), "r abort");
          chk("r abort mem", 32'(dut.ram.mem[a]), 32'(mem_m[a]));
          chk("r abort wr_addr", 32'(dut.ram.wr_addr_q), 32'(wr_addr_m));
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_wrapper.md
Name: spi_ram_wrapper

Overview:
SPI slave (mode-0 style, sampled on clk rising edge) bridged to a 256x8 single-port RAM.
- An external master issues 10-bit command words over MOSI while SS_n is low.
- Commands load a write address, write data, load a read address, or read data.
- Read data is serialized back on MISO.
- Sits as a memory-mapped scratchpad behind an SPI pin interface.

Parameters:
MEM_DEPTH, 256, number of RAM words.
ADDR_SIZE, 8, address width (log2 MEM_DEPTH).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
MOSI  input  1  serial data from master, sampled on rising clk.
SS_n  input  1  slave select, active-low; high aborts or ends a frame.
MISO  output  1  serial read data to master.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.

Reset:
- FSM enters IDLE; shift counter = 0; MISO = 0.
- rd_addr_received flag = 0; RAM wr_addr, rd_addr and dout = 0; tx_valid = 0.
- RAM contents are not cleared.

FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD.
- CHK_CMD: SS_n=1 -> IDLE. Otherwise sample MOSI:
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_received=1 -> READ_DATA.
  - MOSI=1 and rd_addr_received=0 -> READ_ADD.
  - The selector bit is not shifted into the word.
- WRITE / READ_ADD / READ_DATA: shift MOSI MSB-first into 10-bit din on each cycle.
  - After the 10th bit, pulse rx_valid for one cycle with din = {cmd[1:0], payload[7:0]}.
  - Stay in the state until SS_n=1, then -> IDLE.
  - SS_n=1 mid-word returns to IDLE, discards the partial word and clears the counter.

RAM command decode on rx_valid (registered, 1-cycle latency):
- 00: wr_addr <= payload.
- 01: mem[wr_addr] <= payload.
- 10: rd_addr <= payload; slave sets rd_addr_received=1.
- 11: dout <= mem[rd_addr]; tx_valid=1 next cycle. Slave clears rd_addr_received.

Read-data return:
- In READ_DATA, after tx_valid, MISO drives dout[7] through dout[0], one bit per clk starting the cycle after tx_valid.
- MISO returns to 0 after the 8th bit.
- SS_n=1 during serialization aborts it; MISO = 0.
- The payload of a 11 command is don't-care.
- A cmd code mismatched to the selector (e.g. selector 0, cmd 1x) is ignored: no RAM effect.
- Write then read of the same address in consecutive frames returns the new data.
- Address wrap: none needed, since the 8-bit address covers full depth.

Optional Feature:
Macro SPI_WR_ADDR_AUTOINC_EN.
- Defined: after each 01 write, wr_addr increments by 1 modulo MEM_DEPTH (255 -> 0), allowing burst writes without reloading the address.
- Undefined: wr_addr holds until the next 00 command.

Decomposition:
Package spi_ram_pkg holds:
- State enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
- Command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- WORD_W=10.

One sub-module, spi_ram_sp:
- Single-port RAM with command decoder.
- Instantiated as instance name "ram", storage array named "mem" so benches can preload via hierarchical $readmemh.
- The slave FSM lives in the top.

Test Plan:
1. Reset 3 cycles with SS_n=1 -> MISO=0, FSM IDLE, no RAM change.
2. Frame: SS_n low, selector 0, bits 00_11111110 -> wr_addr=254, mem unchanged.
3. Frame: selector 0, bits 01_10101010 -> mem[254]=0xAA one cycle after the 10th bit.
4. Frame: selector 1, bits 10_11111110 -> rd_addr=254, rd_addr_received=1.
5. Frame: selector 1, bits 11_11110000 (dummy), keep SS_n low 12 more cycles -> MISO shows 1,0,1,0,1,0,1,0 starting the cycle after tx_valid, then 0.
6. Abort: raise SS_n after 5 bits of a 01 write -> FSM IDLE, mem unchanged. With SPI_WR_ADDR_AUTOINC_EN: two writes starting at address 255 land at 255 and 0.
